// File: rtl/student_adder_pkg.sv
// Shared defaults and tree-geometry helpers for the FIR back-end adder tree.
package student_adder_pkg;

   localparam int DEF_DATA_W = 31;
   localparam int DEF_NUM_IN = 10;

   // Depth of a binary reduction tree over n operands.
   function automatic int lvl_count(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   // Operand width at tree level j: one growth bit per level keeps sums exact.
   function automatic int lvl_width(input int j, input int data_w = DEF_DATA_W);
      return data_w + j;
   endfunction

   // Number of registered partial sums held at tree level j.
   function automatic int lvl_nodes(input int n, input int j);
      return (n + (1 << j) - 1) >> j;
   endfunction

endpackage

// File: rtl/student_adder_stage.sv
// One registered level of the adder tree: pairwise exact sums, odd leftover
// passed through with one bit of extension, and a travelling valid bit.
module student_adder_stage #(
   parameter int N_IN   = 2,
   parameter int IN_W   = 8,
   parameter bit SIGNED = 1'b1,
   localparam int N_OUT = (N_IN + 1) / 2,
   localparam int OUT_W = IN_W + 1
) (
   input  logic                   clk,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   input  logic [N_IN*IN_W-1:0]   data_i,
   output logic                   valid_o,
   output logic [N_OUT*OUT_W-1:0] data_o
);

   logic [OUT_W-1:0] nxt [N_OUT];

   genvar i;
   for (i = 0; i < N_OUT; i++) begin : g_node
      logic [IN_W-1:0]  a;
      logic [OUT_W-1:0] a_x;
      assign a   = data_i[2*i*IN_W +: IN_W];
      assign a_x = SIGNED ? {a[IN_W-1], a} : {1'b0, a};
      if (2*i + 1 < N_IN) begin : g_pair
         logic [IN_W-1:0]  b;
         logic [OUT_W-1:0] b_x;
         assign b      = data_i[(2*i+1)*IN_W +: IN_W];
         assign b_x    = SIGNED ? {b[IN_W-1], b} : {1'b0, b};
         assign nxt[i] = a_x + b_x;
      end else begin : g_pass
         assign nxt[i] = a_x;
      end
   end

   // Partial sums only move with a valid launch so the final level holds its value.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            for (int n = 0; n < N_OUT; n++) begin
               data_o[n*OUT_W +: OUT_W] <= nxt[n];
            end
         end
      end
   end

endmodule

// File: rtl/student_adder_tree.sv
// Collects per-channel FIR samples that arrive on independent strobes and,
// once every channel has delivered, launches the set into a pipelined tree.
module student_adder_tree
   import student_adder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter bit SIGNED = 1'b1,
   localparam int LVL   = lvl_count(NUM_IN),
   localparam int OUT_W = DATA_W + LVL
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic [NUM_IN-1:0]        valid_i,
   input  logic [NUM_IN*DATA_W-1:0] data_i,
   input  logic                     flush_i,
   output logic [OUT_W-1:0]         sum_o,
   output logic                     valid_o,
   output logic                     err_o,
   output logic                     busy_o
);

   logic [NUM_IN-1:0]        cap;
   logic [DATA_W-1:0]        hold [NUM_IN];
   logic [NUM_IN*DATA_W-1:0] s0_data;
   logic                     s0_valid;
   logic                     launch;
   logic                     collide;

   // A strobe arriving on the completing edge counts toward the set directly.
   assign launch  = !flush_i && (&(cap | valid_i));
   assign collide = !flush_i && (|(cap & valid_i));
   assign busy_o  = |cap;

   // Capture mask and holding registers; flush drops the partial set and its strobes.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cap <= '0;
         for (int k = 0; k < NUM_IN; k++) begin
            hold[k] <= '0;
         end
      end else if (flush_i) begin
         cap <= '0;
      end else begin
         cap <= launch ? '0 : (cap | valid_i);
         for (int k = 0; k < NUM_IN; k++) begin
            if (valid_i[k]) begin
               hold[k] <= data_i[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Stage 0 takes the fresh sample over the held one so a late or colliding strobe wins.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         s0_valid <= 1'b0;
         s0_data  <= '0;
      end else begin
         s0_valid <= launch;
         if (launch) begin
            for (int k = 0; k < NUM_IN; k++) begin
               s0_data[k*DATA_W +: DATA_W] <= valid_i[k] ? data_i[k*DATA_W +: DATA_W] : hold[k];
            end
         end
      end
   end

   // Collision pulse; several channels colliding on one edge still give one pulse.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o <= 1'b0;
      end else begin
         err_o <= collide;
      end
   end

   genvar j;
   for (j = 0; j < LVL; j++) begin : g_lvl
      localparam int NI = lvl_nodes(NUM_IN, j);
      localparam int NO = lvl_nodes(NUM_IN, j + 1);
      localparam int IW = lvl_width(j, DATA_W);

      logic [NI*IW-1:0]     d_in;
      logic                 v_in;
      logic [NO*(IW+1)-1:0] d_out;
      logic                 v_out;

      if (j == 0) begin : g_first
         assign d_in = s0_data;
         assign v_in = s0_valid;
      end else begin : g_next
         assign d_in = g_lvl[j-1].d_out;
         assign v_in = g_lvl[j-1].v_out;
      end

      student_adder_stage #(
         .N_IN   (NI),
         .IN_W   (IW),
         .SIGNED (SIGNED)
      ) u_stage (
         .clk     (clk),
         .rst_ni  (rst_ni),
         .valid_i (v_in),
         .data_i  (d_in),
         .valid_o (v_out),
         .data_o  (d_out)
      );
   end

   if (LVL == 0) begin : g_out_direct
      assign sum_o   = s0_data;
      assign valid_o = s0_valid;
   end else begin : g_out_tree
      assign sum_o   = g_lvl[LVL-1].d_out;
      assign valid_o = g_lvl[LVL-1].v_out;
   end

endmodule

// File: doc/student_adder_tree.md
# student_adder_tree

Parametrised, pipelined reduction of NUM_IN parallel FIR channel outputs into one sum, succeeding the two-input adder in the FIR back end. Per-channel valid strobes need not coincide. Each channel's sample is captured as it arrives, and the full set is launched into a registered binary adder tree once every channel has delivered. Signed or unsigned mode is selectable, output width grows so the sum never overflows, and repeated strobes before set completion are flagged.

## Interface
- DATA_W, 31: width of each channel sample.
- NUM_IN, 10: channel count, ≥1.
- SIGNED, 1: 1 = two's-complement operands with sign extension; 0 = unsigned with zero extension.
- LVL (localparam): $clog2(NUM_IN), which is the tree depth (0 when NUM_IN=1).
- OUT_W (localparam): DATA_W+LVL.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  NUM_IN  per-channel one-cycle valid strobe.
- data_i  in  NUM_IN×DATA_W  packed channel samples; channel k at bits [k*DATA_W +: DATA_W].
- flush_i  in  1  synchronous discard of a partially captured set.
- sum_o  out  OUT_W  registered sum.
- valid_o  out  1  one-cycle strobe, sum_o valid.
- err_o  out  1  one-cycle pulse on collision.
- busy_o  out  1  high while any channel is captured but not yet launched.

## Operation
- **Capture.** Per-channel holding register plus captured mask cap[NUM_IN-1:0].
  - valid_i[k] loads hold[k] and sets cap[k].
- **Launch condition.** All bits of (cap | valid_i) are 1 at a clock edge.
  - Stage-0 registers load: valid_i[k] ? data_i[k] : hold[k].
  - cap clears to 0 at that edge.
- **Collision.** valid_i[k] while cap[k]=1, with no flush_i.
  - New value overwrites hold[k].
  - err_o pulses the next cycle.
  - If the same edge completes the set, the launch uses the new value.
  - Multiple colliding channels in one cycle produce a single pulse.
- **Flush.** flush_i clears cap at the edge; no launch; collisions are ignored.
  - flush_i has priority over valid_i in the same cycle, so those strobes are discarded.
  - Data already in the tree is unaffected and still emerges.
- **Tree.**
  - Level j holds ceil(NUM_IN/2^j) registered partial sums, each DATA_W+j bits wide.
  - An odd leftover operand passes through a register, extended by one bit.
  - Extension is sign or zero per SIGNED.
  - Sums are exact; no wrap and no saturation.
- **Valid pipeline.** A launch bit travels alongside the data, one register per level. Its final stage drives valid_o.
- **Output holding.** sum_o holds its last value between strobes. valid_o and err_o are 0 otherwise.
- **busy_o** = |cap.
- **Throughput.** One launch per cycle is possible; the tree is fully pipelined and has no back-pressure.

## Timing
- **Reset values.** sum_o=0, valid_o=0, err_o=0, busy_o=0. cap, hold and all tree registers are 0.
- **Reset mid-operation.** Captured channels and in-flight sums are lost; no valid_o follows.
- **Latency.** Completing edge at E puts stage 0 valid after E. valid_o and sum_o are visible in the cycle after edge E+LVL.
  - NUM_IN=10: valid_o high 5 cycles after the completing strobe cycle.
  - NUM_IN=1: high 1 cycle after.
- **err_o:** the cycle after the colliding edge.
- **busy_o:** rises the cycle after the first capture; falls the cycle after launch or flush.
- **Back-to-back.** Strobes arriving in the launch cycle for the next set are not possible for launched channels, because the launch consumed them. The next set starts at E+1.

## Structure
- **Package student_adder_pkg:**
  - default DATA_W and NUM_IN;
  - function lvl_count(n) returning the clog2 depth;
  - function lvl_width(j) returning DATA_W+j.
- **Sub-module student_adder_stage:** one tree level with parameters N_IN, IN_W and SIGNED.
  - Pairwise adders with extension, registered, with odd pass-through and a valid bit.
  - The top module generates LVL instances.
- The capture and launch logic stays in the top module.

## Test plan
- **Aligned set.** NUM_IN=10, SIGNED=1, all valid_i together with data k+1 for k=0..9 → valid_o single pulse 5 cycles later, sum_o=55.
- **Staggered arrival.** Channels strobe one per cycle over 10 cycles, each data=-1 → busy_o high from cycle 2 to launch, sum_o=-10 sign-extended to 35 bits, one valid_o.
- **Collision.** Channel 3 strobes 7 then 100, then the others strobe 0 → err_o pulses once, sum_o=100.
- **Flush.** Channels 0–4 strobe 5, then flush_i, then all 10 strobe 1 → sum_o=10. No output from the flushed partial set, and no err_o.
- **Unsigned extremes.** SIGNED=0, DATA_W=31, all inputs 2^31-1 → sum_o=10·(2^31-1) exactly, no wrap.
- **Reset and streaming.** Assert rst_ni low mid-tree → no valid_o, all outputs 0. Then streaming launches on consecutive cycles produce valid_o every cycle with matching sums.
